// File: rtl/jtbubl_rom_sched_if.sv
// Bus bundle between the four CPU ROM slots, the ROM scheduler and the SDRAM read port.
// The master modport is the surrounding system (CPUs plus SDRAM controller).
// The slave modport is the scheduler itself.
interface jtbubl_rom_sched_if #(
    parameter int SLOT_AW = 17
);
    // CPU slot side, one entry per slot (0 main, 1 sub, 2 MCU, 3 sound)
    logic [3:0]              slot_cs;
    logic [3:0][SLOT_AW-1:0] slot_addr;
    logic [3:0]              slot_ok;
    logic [3:0][7:0]         slot_dout;

    // ROM download in progress
    logic                    downloading;

    // SDRAM read port
    logic                    sdram_req;
    logic [21:0]             sdram_addr;
    logic                    sdram_ack;
    logic                    data_rdy;
    logic [31:0]             data_read;
    logic                    refresh_en;

    modport master (
        output slot_cs, slot_addr, downloading, sdram_ack, data_rdy, data_read,
        input  slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
    );

    modport slave (
        input  slot_cs, slot_addr, downloading, sdram_ack, data_rdy, data_read,
        output slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
    );
endinterface

// File: rtl/jtbubl_rom_sched.sv
// ROM read scheduler for the four jtbubl CPU slots.
// Each slot owns a one-line (32-bit) cache; misses share a single SDRAM read
// port and are granted round-robin, starting after the last slot served.
module jtbubl_rom_sched #(
    parameter int          SLOT_AW      = 17,
    parameter logic [21:0] SLOT0_OFFSET = 22'h0,
    parameter logic [21:0] SLOT1_OFFSET = 22'h0,
    parameter logic [21:0] SLOT2_OFFSET = 22'h0,
    parameter logic [21:0] SLOT3_OFFSET = 22'h0
) (
    input  logic              clk,
    input  logic              rst,
    jtbubl_rom_sched_if.slave bus
);

    localparam int TW = SLOT_AW - 2;
    localparam logic [21:0] OFFSET [4] = '{SLOT0_OFFSET, SLOT1_OFFSET, SLOT2_OFFSET, SLOT3_OFFSET};

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_RDY
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [3:0]           valid;
    logic [3:0][TW-1:0]   tag;
    logic [3:0][31:0]     line;
    logic [1:0]           rr;

    logic [1:0]           sel;
    logic [TW-1:0]        sel_tag;
    logic                 req_r;
    logic [21:0]          addr_r;

    logic [3:0]           hit;
    logic [3:0]           miss;
    logic [3:0]           ok;
    logic [3:0][7:0]      dout;
    logic [21:0]          word_addr [4];

    logic                 pick_valid;
    logic [1:0]           pick;
    logic [1:0]           cand;
    logic                 fill;

    // Per-slot hit/miss detection, byte selection and SDRAM word address of the slot's line
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hit[i]       = valid[i] && (tag[i] == bus.slot_addr[i][SLOT_AW-1:2]);
            miss[i]      = bus.slot_cs[i] && !hit[i] && !bus.downloading;
            ok[i]        = bus.slot_cs[i] && hit[i] && !bus.downloading;
            dout[i]      = line[i][{bus.slot_addr[i][1:0], 3'b000} +: 8];
            word_addr[i] = OFFSET[i] + 22'({bus.slot_addr[i][SLOT_AW-1:2], 1'b0});
        end
    end

    // Round-robin pick: first missing slot after rr, with rr itself considered last
    always_comb begin
        pick_valid = 1'b0;
        pick       = rr;
        cand       = rr;
        for (int k = 1; k <= 4; k++) begin
            cand = rr + 2'(k);
            if (!pick_valid && miss[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    // Next-state logic; a download aborts whatever fill is in flight
    always_comb begin
        state_nxt = state;
        fill      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.sdram_ack) begin
                    if (bus.data_rdy) begin
                        fill      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                if (bus.data_rdy) begin
                    fill      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.downloading) begin
            state_nxt = IDLE;
            fill      = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch: slot index, tag and word address are frozen for the whole fill
    always_ff @(posedge clk) begin
        if (rst) begin
            req_r   <= 1'b0;
            addr_r  <= 22'h0;
            sel     <= 2'd0;
            sel_tag <= '0;
        end else if (bus.downloading) begin
            req_r <= 1'b0;
        end else if (state == IDLE && pick_valid) begin
            req_r   <= 1'b1;
            addr_r  <= word_addr[pick];
            sel     <= pick;
            sel_tag <= bus.slot_addr[pick][SLOT_AW-1:2];
        end else if (state == WAIT_ACK && bus.sdram_ack) begin
            req_r <= 1'b0;
        end
    end

    // Line caches and round-robin pointer; downloads invalidate everything
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 4'b0;
            tag   <= '0;
            line  <= '0;
            rr    <= 2'd0;
        end else if (bus.downloading) begin
            valid <= 4'b0;
        end else if (fill) begin
            valid[sel] <= 1'b1;
            tag[sel]   <= sel_tag;
            line[sel]  <= bus.data_read;
            rr         <= sel;
        end
    end

    // Output drive; the request is masked immediately when a download starts
    always_comb begin
        bus.slot_ok    = ok;
        bus.slot_dout  = dout;
        bus.sdram_req  = req_r && !bus.downloading;
        bus.sdram_addr = addr_r;
        bus.refresh_en = bus.downloading || (state == IDLE && !pick_valid);
    end

endmodule
